// File: rtl/symbol_match_pkg.sv
// Shared constants and helpers for the symbol match window counter.
package symbol_match_pkg;

  localparam logic MODE_ALIGNED = 1'b0;
  localparam logic MODE_DELAYED = 1'b1;

  localparam int POP_MAX_W = 64;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int popcount(input logic [POP_MAX_W-1:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (bits[i]) begin
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/symbol_match_window_counter_hist.sv
// Sliding-window sum of per-sample match counts over the last DEPTH pushes.
module match_window_hist
  import symbol_match_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WCNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              clear,
  input  logic [WCNT_W-1:0] count_in,
  output logic [WCNT_W-1:0] window_count,
  output logic              window_valid
);

  localparam int FILL_W = clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [WCNT_W-1:0] hist_r [DEPTH];
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_next_s;
  logic [WCNT_W-1:0] sum_r;
  logic [WCNT_W-1:0] sum_next_s;
  logic              valid_r;

  // Oldest slot reads 0 until DEPTH pushes have occurred, so the sum stays exact while filling.
  always_comb begin
    fill_next_s = fill_r;
    if (fill_r == FILL_FULL) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FILL_W'(1);
    end
    sum_next_s = sum_r + count_in - hist_r[DEPTH-1];
  end

  // History shift, fill tracking and incremental window sum.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {WCNT_W{1'b0}};
      end
      fill_r  <= {FILL_W{1'b0}};
      sum_r   <= {WCNT_W{1'b0}};
      valid_r <= 1'b0;
    end else if (push) begin
      hist_r[0] <= count_in;
      for (int i = 1; i < DEPTH; i++) begin
        hist_r[i] <= hist_r[i-1];
      end
      fill_r  <= fill_next_s;
      sum_r   <= sum_next_s;
      valid_r <= (fill_next_s == FILL_FULL);
    end else begin
      fill_r  <= fill_r;
      sum_r   <= sum_r;
      valid_r <= valid_r;
    end
  end

  assign window_count = sum_r;
  assign window_valid = valid_r;

endmodule

// File: rtl/symbol_match_window_counter.sv
// Lane-wise masked symbol compare with saturating total and sliding-window match counts.
module symbol_match_window_counter
  import symbol_match_pkg::*;
#(
  parameter int SYM_W  = 4,
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int WCNT_W = clog2(DEPTH * LANES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [LANES*SYM_W-1:0] a,
  input  logic [LANES*SYM_W-1:0] b,
  input  logic                   mode,
  input  logic [SYM_W-1:0]       mask,
  input  logic                   clear,
  input  logic [WCNT_W-1:0]      thresh,
  output logic [LANES-1:0]       match_vec,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       total_count,
  output logic                   total_sat,
  output logic [WCNT_W-1:0]      window_count,
  output logic                   window_valid,
  output logic                   above_thresh
);

  localparam int W     = LANES * SYM_W;
  localparam int SUM_W = CNT_W + clog2(LANES + 1);
  localparam logic [CNT_W-1:0] TOTAL_MAX     = {CNT_W{1'b1}};
  localparam logic [SUM_W-1:0] TOTAL_MAX_EXT = {{(SUM_W-CNT_W){1'b0}}, TOTAL_MAX};

  logic [W-1:0]      b_prev_r;
  logic [W-1:0]      ref_s;
  logic [LANES-1:0]  lane_match_s;
  int                pop_s;
  logic [WCNT_W-1:0] match_cnt_s;
  logic [SUM_W-1:0]  total_sum_s;
  logic [CNT_W-1:0]  total_next_s;
  logic              accept_s;

  logic [LANES-1:0]  match_vec_r;
  logic              out_valid_r;
  logic [CNT_W-1:0]  total_r;
  logic              total_sat_r;
  logic [WCNT_W-1:0] window_count_s;
  logic              window_valid_s;

  assign accept_s = in_valid & ~clear;

  // Masked lane compare: bits with mask=0 always count as equal.
  always_comb begin
    ref_s        = (mode == MODE_ALIGNED) ? b : b_prev_r;
    lane_match_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_match_s[i] = &((a[i*SYM_W +: SYM_W] ~^ ref_s[i*SYM_W +: SYM_W]) | ~mask);
    end
    pop_s       = popcount(POP_MAX_W'(lane_match_s));
    match_cnt_s = WCNT_W'(pop_s);
  end

  // Saturating next total, widened so the add cannot wrap before the clamp.
  always_comb begin
    total_sum_s = {{(SUM_W-CNT_W){1'b0}}, total_r} + SUM_W'(pop_s);
    if (total_sum_s >= TOTAL_MAX_EXT) begin
      total_next_s = TOTAL_MAX;
    end else begin
      total_next_s = total_sum_s[CNT_W-1:0];
    end
  end

  // Result, total and previous-B registers; clear keeps b_prev so delayed mode survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_vec_r <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      total_r     <= {CNT_W{1'b0}};
      total_sat_r <= 1'b0;
      b_prev_r    <= {W{1'b0}};
    end else if (clear) begin
      match_vec_r <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
      total_r     <= {CNT_W{1'b0}};
      total_sat_r <= 1'b0;
      b_prev_r    <= b_prev_r;
    end else if (in_valid) begin
      match_vec_r <= lane_match_s;
      out_valid_r <= 1'b1;
      total_r     <= total_next_s;
      total_sat_r <= total_sat_r | (total_next_s == TOTAL_MAX);
      b_prev_r    <= b;
    end else begin
      match_vec_r <= match_vec_r;
      out_valid_r <= 1'b0;
      total_r     <= total_r;
      total_sat_r <= total_sat_r;
      b_prev_r    <= b_prev_r;
    end
  end

  match_window_hist #(
    .DEPTH  (DEPTH),
    .WCNT_W (WCNT_W)
  ) u_hist (
    .clk          (clk),
    .reset        (reset),
    .push         (accept_s),
    .clear        (clear),
    .count_in     (match_cnt_s),
    .window_count (window_count_s),
    .window_valid (window_valid_s)
  );

  assign match_vec    = match_vec_r;
  assign out_valid    = out_valid_r;
  assign total_count  = total_r;
  assign total_sat    = total_sat_r;
  assign window_count = window_count_s;
  assign window_valid = window_valid_s;
  assign above_thresh = (window_count_s >= thresh);

endmodule

// File: tb/tb_symbol_match_window_counter.sv
// Scoreboard bench: a reference model predicts every cycle, scenario tasks add targeted checks.
module tb_symbol_match_window_counter;

  logic       clk = 1'b0;
  logic       reset, in_valid, mode, clear;
  logic [7:0] a, b;
  logic [3:0] mask, thresh;

  logic [1:0] match_vec, match_vec4;
  logic       out_valid, out_valid4;
  logic [7:0] total_count;
  logic [3:0] total_count4;
  logic       total_sat, total_sat4;
  logic [3:0] window_count, window_count4;
  logic       window_valid, window_valid4;
  logic       above_thresh, above_thresh4;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [1:0] mv;
    logic       ov;
    logic [7:0] tot;
    logic       sat;
    logic [3:0] tot4;
    logic       sat4;
    logic [3:0] win;
    logic       wv;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_bprev = 8'h00;
  logic [1:0] m_mv    = 2'b00;
  logic       m_ov    = 1'b0;
  int         m_tot   = 0;
  int         m_tot4  = 0;
  logic       m_sat   = 1'b0;
  logic       m_sat4  = 1'b0;
  int         m_hist[$];
  int         m_fill  = 0;

  always #5 clk = ~clk;

  symbol_match_window_counter #(.SYM_W(4), .LANES(2), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .mask(mask),
    .clear(clear), .thresh(thresh), .match_vec(match_vec), .out_valid(out_valid),
    .total_count(total_count), .total_sat(total_sat), .window_count(window_count),
    .window_valid(window_valid), .above_thresh(above_thresh)
  );

  symbol_match_window_counter #(.SYM_W(4), .LANES(2), .DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .mask(mask),
    .clear(clear), .thresh(thresh), .match_vec(match_vec4), .out_valid(out_valid4),
    .total_count(total_count4), .total_sat(total_sat4), .window_count(window_count4),
    .window_valid(window_valid4), .above_thresh(above_thresh4)
  );

  // Drive one cycle, predict with the model, then pop and compare after the edge.
  task automatic drive(input logic rst, input logic v, input logic clr, input logic [7:0] ai,
                       input logic [7:0] bi, input logic md, input logic [3:0] mk);
    exp_t e;
    logic [7:0] r;
    int pc, win;
    reset = rst; in_valid = v; clear = clr; a = ai; b = bi; mode = md; mask = mk;
    if (rst || clr) begin
      if (rst) m_bprev = 8'h00;
      m_mv = 2'b00; m_ov = 1'b0; m_tot = 0; m_tot4 = 0; m_sat = 1'b0; m_sat4 = 1'b0;
      m_hist.delete(); m_fill = 0;
    end else if (v) begin
      r = md ? m_bprev : bi;
      for (int l = 0; l < 2; l++) m_mv[l] = ((ai[l*4 +: 4] & mk) == (r[l*4 +: 4] & mk));
      pc = int'(m_mv[0]) + int'(m_mv[1]);
      m_ov = 1'b1;
      m_tot  = (m_tot + pc > 255) ? 255 : m_tot + pc;
      m_tot4 = (m_tot4 + pc > 15) ? 15 : m_tot4 + pc;
      if (m_tot == 255) m_sat = 1'b1;
      if (m_tot4 == 15) m_sat4 = 1'b1;
      m_hist.push_front(pc);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      if (m_fill < 4) m_fill++;
      m_bprev = bi;
    end else begin
      m_ov = 1'b0;
    end
    win = 0;
    foreach (m_hist[k]) win += m_hist[k];
    e.mv = m_mv; e.ov = m_ov; e.tot = 8'(m_tot); e.sat = m_sat; e.tot4 = 4'(m_tot4);
    e.sat4 = m_sat4; e.win = 4'(win); e.wv = (m_fill == 4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_total += 10;
    if (match_vec !== e.mv) begin n_bad++; $display("FAIL sb_match_vec: got %b expected %b", match_vec, e.mv); end
    if (out_valid !== e.ov) begin n_bad++; $display("FAIL sb_out_valid: got %b expected %b", out_valid, e.ov); end
    if (total_count !== e.tot) begin n_bad++; $display("FAIL sb_total: got %0d expected %0d", total_count, e.tot); end
    if (total_sat !== e.sat) begin n_bad++; $display("FAIL sb_total_sat: got %b expected %b", total_sat, e.sat); end
    if (total_count4 !== e.tot4) begin n_bad++; $display("FAIL sb_total4: got %0d expected %0d", total_count4, e.tot4); end
    if (total_sat4 !== e.sat4) begin n_bad++; $display("FAIL sb_total_sat4: got %b expected %b", total_sat4, e.sat4); end
    if (window_count !== e.win) begin n_bad++; $display("FAIL sb_window: got %0d expected %0d", window_count, e.win); end
    if (window_valid !== e.wv) begin n_bad++; $display("FAIL sb_window_valid: got %b expected %b", window_valid, e.wv); end
    if (above_thresh !== (e.win >= thresh)) begin n_bad++; $display("FAIL sb_above: got %b expected %b", above_thresh, (e.win >= thresh)); end
    if (match_vec4 !== e.mv) begin n_bad++; $display("FAIL sb_match_vec4: got %b expected %b", match_vec4, e.mv); end
  endtask

  task automatic test_reset();
    thresh = 4'd0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'hF);
    drive(1'b1, 1'b1, 1'b0, 8'h12, 8'h12, 1'b0, 4'hF);
    n_total += 3;
    if (total_count !== 8'd0 || window_count !== 4'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", total_count, window_count); end
    if (out_valid !== 1'b0 || match_vec !== 2'b00) begin n_bad++; $display("FAIL reset_outputs: got %b/%b expected 0/00", out_valid, match_vec); end
    if (above_thresh !== 1'b1) begin n_bad++; $display("FAIL reset_above_thresh0: got %b expected 1", above_thresh); end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, 4'hF);
    n_total += 4;
    if (match_vec !== 2'b11) begin n_bad++; $display("FAIL basic_match: got %b expected 11", match_vec); end
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    if (total_count !== 8'd2 || window_count !== 4'd2) begin n_bad++; $display("FAIL basic_counts: got %0d/%0d expected 2/2", total_count, window_count); end
    if (window_valid !== 1'b0) begin n_bad++; $display("FAIL basic_window_valid: got %b expected 0", window_valid); end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 4'hF);
    n_total += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
    if (total_count !== 8'd2 || window_count !== 4'd2 || match_vec !== 2'b11) begin n_bad++; $display("FAIL idle_hold: got %0d/%0d/%b expected 2/2/11", total_count, window_count, match_vec); end
  endtask

  task automatic test_mask();
    logic [3:0] masks[3] = '{4'hF, 4'hC, 4'h0};
    logic [1:0] want[3]  = '{2'b10, 2'b11, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA6, 1'b0, masks[i]);
      n_total++;
      if (match_vec !== want[i]) begin n_bad++; $display("FAIL mask_%0d: got %b expected %b", i, match_vec, want[i]); end
    end
  endtask

  task automatic test_window();
    int win_tab[8] = '{2, 4, 6, 8, 8, 8, 6, 4};
    logic wv_tab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'hF);
    thresh = 4'd7;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0, 4'hF);
      else       drive(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 4'hF);
      n_total += 3;
      if (window_count !== 4'(win_tab[i])) begin n_bad++; $display("FAIL window_%0d: got %0d expected %0d", i, window_count, win_tab[i]); end
      if (window_valid !== wv_tab[i]) begin n_bad++; $display("FAIL window_valid_%0d: got %b expected %b", i, window_valid, wv_tab[i]); end
      if (above_thresh !== (win_tab[i] == 8)) begin n_bad++; $display("FAIL above_%0d: got %b expected %b", i, above_thresh, (win_tab[i] == 8)); end
    end
    thresh = 4'd0;
  endtask

  task automatic test_saturate();
    int tot_tab[9] = '{2, 4, 6, 8, 10, 12, 14, 15, 15};
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'hF);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h77, 8'h77, 1'b0, 4'hF);
      n_total += 2;
      if (total_count4 !== 4'(tot_tab[i])) begin n_bad++; $display("FAIL sat_total_%0d: got %0d expected %0d", i, total_count4, tot_tab[i]); end
      if (total_sat4 !== (i >= 7)) begin n_bad++; $display("FAIL sat_flag_%0d: got %b expected %b", i, total_sat4, (i >= 7)); end
    end
  endtask

  task automatic test_delayed();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'hF);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h55, 8'hAA, 1'b1, 4'hF);
    drive(1'b0, 1'b1, 1'b0, 8'h3C, 8'hFF, 1'b1, 4'hF);
    n_total++;
    if (match_vec !== 2'b11) begin n_bad++; $display("FAIL delayed_match: got %b expected 11", match_vec); end
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 4'hF);
    n_total += 2;
    if (total_count !== 8'd0 || window_count !== 4'd0) begin n_bad++; $display("FAIL clear_counts: got %0d/%0d expected 0/0", total_count, window_count); end
    if (out_valid !== 1'b0 || window_valid !== 1'b0) begin n_bad++; $display("FAIL clear_flags: got %b/%b expected 0/0", out_valid, window_valid); end
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 8'h12, 1'b1, 4'hF);
    n_total++;
    if (match_vec !== 2'b11) begin n_bad++; $display("FAIL clear_keeps_bprev: got %b expected 11", match_vec); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h9C, 8'h9C, 1'b0, 4'hF);
    drive(1'b1, 1'b1, 1'b0, 8'h9C, 8'h9C, 1'b0, 4'hF);
    n_total += 2;
    if (total_count !== 8'd0 || window_count !== 4'd0 || total_count4 !== 4'd0) begin n_bad++; $display("FAIL midreset_counts: got %0d/%0d/%0d expected 0/0/0", total_count, window_count, total_count4); end
    if (out_valid !== 1'b0 || match_vec !== 2'b00 || window_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_flags: got %b/%b/%b expected 0/00/0", out_valid, match_vec, window_valid); end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b1, 4'hF);
    n_total++;
    if (match_vec !== 2'b11) begin n_bad++; $display("FAIL midreset_bprev0: got %b expected 11", match_vec); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ai, bi;
    for (int i = 0; i < 60; i++) begin
      ai = 8'($urandom);
      bi = ($urandom_range(0, 1) == 0) ? ai ^ 8'($urandom_range(0, 3) << (4 * $urandom_range(0, 1))) : 8'($urandom);
      thresh = 4'($urandom_range(0, 8));
      drive(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), ai, bi,
            1'($urandom_range(0, 1)), 4'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; mode = 1'b0;
    a = 8'h00; b = 8'h00; mask = 4'hF; thresh = 4'd0;
    test_reset();
    test_basic();
    test_mask();
    test_window();
    test_saturate();
    test_delayed();
    test_reset_mid();
    test_back_to_back();
    n_total++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
